axis_pattern_gen: RTL and testbench

AXIS_PATTERN_GEN -- requirements
Module: axis_pattern_gen

---
 rtl/axis_pkg.sv | 15 +
 rtl/axis_pattern_step.sv | 27 ++
 rtl/axis_pattern_gen.sv | 123 ++++++++++++
 tb/tb_axis_pattern_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared constants for the AXI-Stream pattern generator: pattern mode codes,
// FSM state encoding and the default LFSR feedback mask.
package axis_pkg;

  localparam logic [1:0] PAT_INCR  = 2'd0;
  localparam logic [1:0] PAT_DECR  = 2'd1;
  localparam logic [1:0] PAT_CONST = 2'd2;
  localparam logic [1:0] PAT_LFSR  = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [31:0] DEFAULT_LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/axis_pattern_step.sv
// Combinational next-beat data function for the pattern generator.
module axis_pattern_step
  import axis_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] step,
  input  logic [DATA_W-1:0] taps,
  output logic [DATA_W-1:0] next_data
);

  // LFSR shifts left and feeds the parity of the tapped bits into bit 0;
  // an all-zero state stays at zero on purpose.
  always_comb begin
    next_data = data;
    case (mode)
      PAT_INCR:  next_data = data + step;
      PAT_DECR:  next_data = data - step;
      PAT_CONST: next_data = data;
      PAT_LFSR:  next_data = {data[DATA_W-2:0], ^(data & taps)};
      default:   next_data = data;
    endcase
  end

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI-Stream burst pattern generator (INCR/DECR/CONST/LFSR).
// Define AXIS_PATTERN_GEN_TLAST_EN to drive m_axis_tlast on each burst's final beat.
module axis_pattern_gen
  import axis_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                LEN_W     = 16,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(DEFAULT_LFSR_TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] step,
  input  logic [LEN_W-1:0]  len,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  beat_cnt
);

  logic [0:0]        state_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] step_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] data_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              tvalid_q;
  logic              done_q;
  logic [DATA_W-1:0] next_data;
  logic              handshake;
  logic              final_beat;

  assign handshake  = tvalid_q && m_axis_tready;
  assign final_beat = (cnt_q == len_q - LEN_W'(1));

  axis_pattern_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .mode      (mode_q),
    .data      (data_q),
    .step      (step_q),
    .taps      (LFSR_TAPS),
    .next_data (next_data)
  );

  // Burst control: configuration is captured once at acceptance so input
  // changes during a burst cannot disturb it; start is only looked at in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= PAT_INCR;
      step_q   <= '0;
      len_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && (len != '0)) begin
            state_q  <= ST_RUN;
            mode_q   <= mode;
            step_q   <= step;
            len_q    <= len;
            data_q   <= seed;
            cnt_q    <= '0;
            tvalid_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (handshake) begin
            cnt_q <= cnt_q + LEN_W'(1);
            if (final_beat) begin
              state_q  <= ST_IDLE;
              tvalid_q <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              data_q <= next_data;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          tvalid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXIS_PATTERN_GEN_TLAST_EN
  logic tlast_q;

  // tlast is registered alongside the beat it marks: set when the beat about
  // to be presented is the last one of the burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      tlast_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      tlast_q <= start && (len == LEN_W'(1));
    end else if (handshake) begin
      tlast_q <= !final_beat && (cnt_q == len_q - LEN_W'(2));
    end
  end

  assign m_axis_tlast = tlast_q;
`else
  assign m_axis_tlast = 1'b0;
`endif

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = data_q;
  assign busy          = (state_q == ST_RUN);
  assign done          = done_q;
  assign beat_cnt      = cnt_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Randomized self-checking bench for axis_pattern_gen against a beat-list model.
module tb_axis_pattern_gen;

  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic [31:0] step;
  logic [15:0] len;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        tready;
  logic        busy;
  logic        done;
  logic [15:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  axis_pattern_gen dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .mode          (mode),
    .seed          (seed),
    .step          (step),
    .len           (len),
    .m_axis_tvalid (tvalid),
    .m_axis_tdata  (tdata),
    .m_axis_tlast  (tlast),
    .m_axis_tready (tready),
    .busy          (busy),
    .done          (done),
    .beat_cnt      (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference pattern rule written as plain arithmetic on the current beat.
  function automatic logic [31:0] modelNext(input logic [1:0] m, input logic [31:0] d, input logic [31:0] st);
    logic [31:0] r;
    case (m)
      2'd0:    r = d + st;
      2'd1:    r = d - st;
      2'd2:    r = d;
      default: r = (d * 2) + 32'($countones(d & TAPS) % 2);
    endcase
    return r;
  endfunction

  function automatic logic expLast(input int idx, input int ln);
`ifdef AXIS_PATTERN_GEN_TLAST_EN
    return (idx == ln - 1);
`else
    return 1'b0;
`endif
  endfunction

  // rmode: 0 always ready, 1 ready pattern 1,0,0 repeating, 2 random ready.
  // started: burst already accepted by the caller; hold: keep start high throughout.
  task automatic applyStimulus(input logic [1:0] m, input logic [31:0] sd, input logic [31:0] st,
                               input logic [15:0] ln, input int rmode, input bit started, input bit hold);
    logic [31:0] exp[$];
    logic [31:0] d;
    int idx, cyc, stalls, lim;
    bit r;
    d = sd;
    for (int i = 0; i < int'(ln); i++) begin
      exp.push_back(d);
      d = modelNext(m, d, st);
    end
    if (!started) begin
      @(negedge clk);
      mode = m; seed = sd; step = st; len = ln; start = 1'b1;
      @(posedge clk);
    end
    idx = 0; cyc = 0; stalls = 0;
    lim = int'(ln) * 4 + 20;
    while (idx < int'(ln) && cyc < lim) begin
      @(negedge clk);
      if (!hold) begin
        start = 1'b0;
        mode  = 2'($urandom_range(0, 3));
        step  = $urandom;
        len   = 16'($urandom_range(1, 20));
        seed  = $urandom;
      end
      checkOutput("tvalid", 64'(tvalid), 64'd1);
      checkOutput("tdata", 64'(tdata), 64'(exp[idx]));
      checkOutput("tlast", 64'(tlast), 64'(expLast(idx, int'(ln))));
      checkOutput("beat_cnt", 64'(beat_cnt), 64'(idx));
      checkOutput("busy", 64'(busy), 64'd1);
      checkOutput("done_run", 64'(done), 64'd0);
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = ($urandom_range(0, 1) == 1) || (stalls >= 3);
      endcase
      stalls = r ? 0 : stalls + 1;
      tready = r;
      @(posedge clk);
      if (r) idx++;
      cyc++;
    end
    if (idx < int'(ln)) checkOutput("timeout", 64'd0, 64'd1);
    @(negedge clk);
    checkOutput("end_tvalid", 64'(tvalid), 64'd0);
    checkOutput("end_done", 64'(done), 64'd1);
    checkOutput("end_beat_cnt", 64'(beat_cnt), 64'(ln));
    checkOutput("end_busy", 64'(busy), 64'd0);
    checkOutput("end_tlast", 64'(tlast), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'd0; seed = '0; step = '0; len = '0; tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tvalid", 64'(tvalid), 64'd0);
    checkOutput("rst_tdata", 64'(tdata), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    // Reset wins over a simultaneous start.
    start = 1'b1; len = 16'd3;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_prio_tvalid", 64'(tvalid), 64'd0);
    reset = 1'b0; start = 1'b0;

    $display("[TB] directed patterns");
    applyStimulus(2'd0, 32'd10, 32'd3, 16'd4, 0, 1'b0, 1'b0);
    applyStimulus(2'd1, 32'd1, 32'd2, 16'd3, 0, 1'b0, 1'b0);
    applyStimulus(2'd2, 32'hA5, 32'd7, 16'd5, 1, 1'b0, 1'b0);
    applyStimulus(2'd3, 32'd1, 32'd0, 16'd8, 0, 1'b0, 1'b0);
    applyStimulus(2'd3, 32'd0, 32'd0, 16'd6, 2, 1'b0, 1'b0);
    applyStimulus(2'd0, 32'd42, 32'd1, 16'd1, 2, 1'b0, 1'b0);

    $display("[TB] reset mid-burst");
    @(negedge clk);
    mode = 2'd0; seed = 32'd100; step = 32'd1; len = 16'd6; start = 1'b1; tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_rst_beat_cnt", 64'(beat_cnt), 64'd2);
    checkOutput("pre_rst_tdata", 64'(tdata), 64'd102);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_tvalid", 64'(tvalid), 64'd0);
    checkOutput("abort_beat_cnt", 64'(beat_cnt), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_tdata", 64'(tdata), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_done_after", 64'(done), 64'd0);
    applyStimulus(2'd0, 32'd7, 32'd5, 16'd2, 0, 1'b0, 1'b0);

    $display("[TB] start held and len zero");
    applyStimulus(2'd0, 32'd5, 32'd1, 16'd2, 0, 1'b0, 1'b1);
    applyStimulus(2'd0, 32'd5, 32'd1, 16'd2, 0, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1; len = 16'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("len0_tvalid", 64'(tvalid), 64'd0);
    checkOutput("len0_busy", 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("len0_tvalid2", 64'(tvalid), 64'd0);

    $display("[TB] random bursts");
    for (int n = 0; n < 12; n++) begin
      applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom,
                    16'($urandom_range(1, 12)), $urandom_range(0, 2), 1'b0, 1'b0);
    end

    $display("[TB] maximum length burst");
    applyStimulus(2'd2, 32'h5A5A, 32'd0, 16'hFFFF, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
